// File: rtl/pe_pass_ctrl.sv
// rtl/pe_pass_ctrl.sv - one-pass sequencer for a single PE: shape latch, start strobes, gated bus transfers
module pe_pass_ctrl #(
    parameter int PARA_WIDTH = 8,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_start,
    input  logic [PARA_WIDTH-1:0] cfg_S,
    input  logic [PARA_WIDTH-1:0] cfg_U,
    input  logic [PARA_WIDTH-1:0] cfg_q,
    input  logic [PARA_WIDTH-1:0] cfg_p,
    input  logic [PARA_WIDTH-1:0] cfg_num_win,
    input  logic                  cfg_psum_acc,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err,
    output logic                  start_config,
    output logic                  start_weight_load,
    output logic                  start_feature_load,
    output logic                  start_psum_in_load,
    output logic                  load_full_cloumn,
    output logic                  psum_out_start,
    input  logic                  mac_finish,
    input  logic                  psum_acc_finish,
    input  logic                  fifo_full_filter,
    input  logic                  fifo_full_fmap,
    input  logic                  weight_bus_valid,
    input  logic                  fmap_bus_valid,
    input  logic                  psum_bus_valid,
    output logic                  weight_in_en,
    output logic                  feature_in_en,
    output logic                  psum_in_en,
    output logic [PARA_WIDTH-1:0] win_idx
);

    typedef enum logic [3:0] {
        S_IDLE, S_CFG, S_WSTRT, S_WLOAD, S_FSTRT, S_FLOAD,
        S_MACW, S_PSTRT, S_PLOAD, S_OUT, S_OUTW, S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [PARA_WIDTH-1:0] WIN_ONE = PARA_WIDTH'(1);
    localparam logic [PARA_WIDTH-1:0] P_ZERO  = '0;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [PARA_WIDTH-1:0] win_q, win_d;
    logic [PARA_WIDTH-1:0] num_win_q, num_win_d;
    logic                  acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  w_tot_q, w_tot_d;
    logic [CNT_WIDTH-1:0]  f_full_q, f_full_d;
    logic [CNT_WIDTH-1:0]  f_win_q, f_win_d;
    logic [CNT_WIDTH-1:0]  p_tot_q, p_tot_d;
    logic                  cfg_err_q, cfg_err_d;

    logic [CNT_WIDTH-1:0]  s_ext, u_ext, q_ext, p_ext;
    logic [CNT_WIDTH-1:0]  f_tgt;
    logic [PARA_WIDTH-1:0] win_inc;
    logic                  cfg_bad;

    assign s_ext   = CNT_WIDTH'(cfg_S);
    assign u_ext   = CNT_WIDTH'(cfg_U);
    assign q_ext   = CNT_WIDTH'(cfg_q);
    assign p_ext   = CNT_WIDTH'(cfg_p);
    assign win_inc = win_q + WIN_ONE;
    // The first window loads the full q*S column; later windows only the U*q stride.
    assign f_tgt   = (win_q == P_ZERO) ? f_full_q : f_win_q;
    assign cfg_bad = (cfg_S == P_ZERO) || (cfg_q == P_ZERO) || (cfg_p == P_ZERO) ||
                     (cfg_num_win == P_ZERO) ||
                     ((cfg_U == P_ZERO) && (cfg_num_win > WIN_ONE));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        win_d         = win_q;
        num_win_d     = num_win_q;
        acc_d         = acc_q;
        w_tot_d       = w_tot_q;
        f_full_d      = f_full_q;
        f_win_d       = f_win_q;
        p_tot_d       = p_tot_q;
        cfg_err_d     = 1'b0;
        weight_in_en  = 1'b0;
        feature_in_en = 1'b0;
        psum_in_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        num_win_d = cfg_num_win;
                        acc_d     = cfg_psum_acc;
                        w_tot_d   = p_ext * q_ext * s_ext;
                        f_full_d  = q_ext * s_ext;
                        f_win_d   = u_ext * q_ext;
                        p_tot_d   = p_ext;
                        cnt_d     = '0;
                        win_d     = '0;
                        state_d   = S_CFG;
                    end
                end
            end
            S_CFG:   state_d = S_WSTRT;
            S_WSTRT: state_d = S_WLOAD;
            S_WLOAD: begin
                weight_in_en = weight_bus_valid & ~fifo_full_filter;
                if (weight_in_en) begin
                    if (cnt_q == w_tot_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = S_FSTRT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_FSTRT: state_d = S_FLOAD;
            S_FLOAD: begin
                feature_in_en = fmap_bus_valid & ~fifo_full_fmap;
                if (feature_in_en) begin
                    if (cnt_q == f_tgt - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = S_MACW;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_MACW: begin
                if (mac_finish) begin
                    state_d = acc_q ? S_PSTRT : S_OUT;
                end
            end
            S_PSTRT: state_d = S_PLOAD;
            S_PLOAD: begin
                psum_in_en = psum_bus_valid;
                if (psum_in_en) begin
                    if (cnt_q == p_tot_q - CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            S_OUT:   state_d = S_OUTW;
            S_OUTW: begin
                if (psum_acc_finish) begin
                    win_d   = win_inc;
                    state_d = (win_inc == num_win_q) ? S_DONE : S_FSTRT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A reset mid-transfer must not pop a bus word the PE will never see.
        if (rst) begin
            weight_in_en  = 1'b0;
            feature_in_en = 1'b0;
            psum_in_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            win_q     <= '0;
            num_win_q <= '0;
            acc_q     <= 1'b0;
            w_tot_q   <= '0;
            f_full_q  <= '0;
            f_win_q   <= '0;
            p_tot_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            num_win_q <= num_win_d;
            acc_q     <= acc_d;
            w_tot_q   <= w_tot_d;
            f_full_q  <= f_full_d;
            f_win_q   <= f_win_d;
            p_tot_q   <= p_tot_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign cfg_err            = cfg_err_q;
    assign start_config       = (state_q == S_CFG);
    assign start_weight_load  = (state_q == S_WSTRT);
    assign start_feature_load = (state_q == S_FSTRT);
    assign start_psum_in_load = (state_q == S_PSTRT);
    assign psum_out_start     = (state_q == S_OUT);
    assign load_full_cloumn   = ((state_q == S_FSTRT) || (state_q == S_FLOAD)) && (win_q == P_ZERO);
    assign win_idx            = win_q;

endmodule
